// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller.
//            - Sequencing FSM state encoding.
//            - Forwarding select encodings.
//            - Default statistic counter width.
// Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // Sequencing FSM states
    typedef enum logic [1:0] {
        RUN     = 2'd0,   // normal issue
        WAIT    = 2'd1,   // frozen on data memory, no branch pending
        WAIT_BR = 2'd2    // frozen on data memory, taken branch pending
    } pipe_state_e;

    // ALU operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;   // register file value from ID/EX
    localparam logic [1:0] FWD_MEM = 2'b10;   // EX/MEM ALU result
    localparam logic [1:0] FWD_WB  = 2'b01;   // MEM/WB write-back value

    // Default width of the statistic counters
    localparam int CNT_W_DEFAULT = 16;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_fwd_unit
// Purpose  : Combinational forwarding select for one EX-stage ALU operand.
//            The EX/MEM producer is younger than MEM/WB, so it wins.
//            Register 0 is never forwarded.
// Ports    : src_i            source register of the operand in ID/EX
//            exmem_regwrite_i EX/MEM writes a register
//            exmem_rd_i       EX/MEM destination
//            memwb_regwrite_i MEM/WB writes a register
//            memwb_rd_i       MEM/WB destination
//            fwd_o            operand source select
// Revision : 1.0  initial release
// ============================================================================
module pipe_fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       exmem_regwrite_i,
    input  logic [4:0] exmem_rd_i,
    input  logic       memwb_regwrite_i,
    input  logic [4:0] memwb_rd_i,
    output logic [1:0] fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (exmem_regwrite_i && (exmem_rd_i != 5'd0) && (exmem_rd_i == src_i)) begin
            fwd_o = FWD_MEM;
        end else if (memwb_regwrite_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == src_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule : pipe_fwd_unit
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Hazard and sequencing controller for the 5-stage pipeline.
//            Drives enables and bubble/flush controls of the PC, IF/ID,
//            ID/EX and EX/MEM registers; resolves load-use stalls, taken
//            branch flushes (resolved in MEM) and data-memory wait states;
//            produces EX forwarding selects and saturating statistics.
// Ports    : clk, rst                 clock / async active-high reset
//            id_*                     ID-stage source operands
//            ex_rs, ex_rt             ID/EX source operands
//            idex_memread, idex_rt    load in EX and its destination
//            exmem_*, memwb_*         write-back info of later stages
//            mem_branch_taken         branch in MEM is taken
//            mem_busy                 data memory not ready
//            pc_we .. exmem_bubble    pipeline register controls
//            fwd_a, fwd_b             ALU operand selects
//            stall_cnt, flush_cnt     saturating event counters
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_regwrite,
    input  logic [4:0]       exmem_rd,
    input  logic             memwb_regwrite,
    input  logic [4:0]       memwb_rd,
    input  logic             mem_branch_taken,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_ce,
    output logic             idex_bubble,
    output logic             exmem_ce,
    output logic             exmem_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pipe_state_e      state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             load_use;
    logic             stall_inc, flush_inc;
    logic [1:0]       fwd_a_raw, fwd_b_raw;

    // ------------------------------------------------------------------
    // Forwarding, one unit per ALU operand
    // ------------------------------------------------------------------
    pipe_fwd_unit u_fwd_a (
        .src_i            (ex_rs),
        .exmem_regwrite_i (exmem_regwrite),
        .exmem_rd_i       (exmem_rd),
        .memwb_regwrite_i (memwb_regwrite),
        .memwb_rd_i       (memwb_rd),
        .fwd_o            (fwd_a_raw)
    );

    pipe_fwd_unit u_fwd_b (
        .src_i            (ex_rt),
        .exmem_regwrite_i (exmem_regwrite),
        .exmem_rd_i       (exmem_rd),
        .memwb_regwrite_i (memwb_regwrite),
        .memwb_rd_i       (memwb_rd),
        .fwd_o            (fwd_b_raw)
    );

    // Load in EX whose destination is read by the instruction in ID.
    assign load_use = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

    // ------------------------------------------------------------------
    // Next state and pipeline controls
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_ce      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_ce     = 1'b1;
        exmem_bubble = 1'b0;
        fwd_a        = fwd_a_raw;
        fwd_b        = fwd_b_raw;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (mem_busy) begin
            // Whole pipeline frozen; a taken branch is remembered, not applied.
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            idex_ce   = 1'b0;
            exmem_ce  = 1'b0;
            stall_inc = 1'b1;
            case (state_q)
                RUN:     state_d = mem_branch_taken ? WAIT_BR : WAIT;
                WAIT:    state_d = mem_branch_taken ? WAIT_BR : WAIT;
                WAIT_BR: state_d = WAIT_BR;
                default: state_d = RUN;
            endcase
        end else if (((state_q == RUN) && mem_branch_taken) || (state_q == WAIT_BR)) begin
            // Squash the three younger instructions; PC loads the target.
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            flush_inc    = 1'b1;
            state_d      = RUN;
        end else begin
            state_d = RUN;
            if (load_use) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                stall_inc   = 1'b1;
            end
        end

        // Reset forces every register to load its cleared value.
        if (rst) begin
            pc_we        = 1'b1;
            ifid_we      = 1'b1;
            ifid_flush   = 1'b1;
            idex_ce      = 1'b1;
            idex_bubble  = 1'b1;
            exmem_ce     = 1'b1;
            exmem_bubble = 1'b1;
            fwd_a        = FWD_RF;
            fwd_b        = FWD_RF;
        end
    end

    // ------------------------------------------------------------------
    // State and saturating counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl.
//            Control outputs are grouped as
//            {pc_we, ifid_we, ifid_flush, idex_ce, idex_bubble,
//             exmem_ce, exmem_bubble}.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;

    localparam logic [6:0] C_NORMAL = 7'b1101010;
    localparam logic [6:0] C_LDUSE  = 7'b0001110;
    localparam logic [6:0] C_FLUSH  = 7'b1111111;
    localparam logic [6:0] C_FREEZE = 7'b0000000;
    localparam logic [6:0] C_RESET  = 7'b1111111;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_rs, ex_rt, idex_rt, exmem_rd, memwb_rd;
    logic          id_uses_rt, idex_memread, exmem_regwrite, memwb_regwrite;
    logic          mem_branch_taken, mem_busy;
    logic          pc_we, ifid_we, ifid_flush, idex_ce, idex_bubble, exmem_ce, exmem_bubble;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [6:0]    ctl;

    int tests = 0;
    int fails = 0;

    assign ctl = {pc_we, ifid_we, ifid_flush, idex_ce, idex_bubble, exmem_ce, exmem_bubble};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .ex_rs            (ex_rs),
        .ex_rt            (ex_rt),
        .idex_memread     (idex_memread),
        .idex_rt          (idex_rt),
        .exmem_regwrite   (exmem_regwrite),
        .exmem_rd         (exmem_rd),
        .memwb_regwrite   (memwb_regwrite),
        .memwb_rd         (memwb_rd),
        .mem_branch_taken (mem_branch_taken),
        .mem_busy         (mem_busy),
        .pc_we            (pc_we),
        .ifid_we          (ifid_we),
        .ifid_flush       (ifid_flush),
        .idex_ce          (idex_ce),
        .idex_bubble      (idex_bubble),
        .exmem_ce         (exmem_ce),
        .exmem_bubble     (exmem_bubble),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0;
        idex_memread = 1'b0; idex_rt = 5'd0;
        exmem_regwrite = 1'b0; exmem_rd = 5'd0;
        memwb_regwrite = 1'b0; memwb_rd = 5'd0;
        mem_branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        exmem_regwrite = 1'b1; exmem_rd = 5'd5; ex_rs = 5'd5; ex_rt = 5'd5;
        mem_busy = 1'b1;
        #1;
        tests++;
        if (ctl !== C_RESET) begin fails++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_RESET); end
        tests++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin fails++; $display("FAIL reset_fwd: got %b expected 0000", {fwd_a, fwd_b}); end
        tick();
        tests++;
        if ({stall_cnt, flush_cnt} !== '0) begin fails++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        rst = 1'b0;
        clear_inputs();
        #1;
        tests++;
        if (ctl !== C_NORMAL) begin fails++; $display("FAIL reset_release_ctl: got %b expected %b", ctl, C_NORMAL); end
    endtask

    task automatic test_load_use();
        do_reset();
        idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
        #1;
        tests++;
        if (ctl !== C_LDUSE) begin fails++; $display("FAIL lduse_rs_ctl: got %b expected %b", ctl, C_LDUSE); end
        tick();
        tests++;
        if (stall_cnt !== 4'd1) begin fails++; $display("FAIL lduse_stall_cnt: got %0d expected 1", stall_cnt); end
        idex_memread = 1'b0;
        #1;
        tests++;
        if (ctl !== C_NORMAL) begin fails++; $display("FAIL lduse_after_ctl: got %b expected %b", ctl, C_NORMAL); end
        tick();
        tests++;
        if (stall_cnt !== 4'd1) begin fails++; $display("FAIL lduse_after_cnt: got %0d expected 1", stall_cnt); end
        // Match on rt only counts when the ID instruction reads rt.
        idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1;
        #1;
        tests++;
        if (ctl !== C_LDUSE) begin fails++; $display("FAIL lduse_rt_ctl: got %b expected %b", ctl, C_LDUSE); end
        id_uses_rt = 1'b0;
        #1;
        tests++;
        if (ctl !== C_NORMAL) begin fails++; $display("FAIL lduse_rt_unused_ctl: got %b expected %b", ctl, C_NORMAL); end
    endtask

    task automatic test_zero_guard();
        do_reset();
        idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
        exmem_regwrite = 1'b1; exmem_rd = 5'd0; ex_rs = 5'd0;
        #1;
        tests++;
        if (ctl !== C_NORMAL) begin fails++; $display("FAIL zero_lduse_ctl: got %b expected %b", ctl, C_NORMAL); end
        tests++;
        if (fwd_a !== 2'b00) begin fails++; $display("FAIL zero_fwd_a: got %b expected 00", fwd_a); end
        tick();
        tests++;
        if (stall_cnt !== 4'd0) begin fails++; $display("FAIL zero_stall_cnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        // A load-use hazard is present too; the flush must take priority.
        mem_branch_taken = 1'b1;
        idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
        #1;
        tests++;
        if (ctl !== C_FLUSH) begin fails++; $display("FAIL flush_ctl: got %b expected %b", ctl, C_FLUSH); end
        tick();
        tests++;
        if ({flush_cnt, stall_cnt} !== {4'd1, 4'd0}) begin fails++; $display("FAIL flush_cnts: got %0d/%0d expected 1/0", flush_cnt, stall_cnt); end
        clear_inputs();
        #1;
        tests++;
        if (ctl !== C_NORMAL) begin fails++; $display("FAIL flush_after_ctl: got %b expected %b", ctl, C_NORMAL); end
        tick();
        tests++;
        if (flush_cnt !== 4'd1) begin fails++; $display("FAIL flush_once: got %0d expected 1", flush_cnt); end
    endtask

    task automatic test_branch_wait();
        do_reset();
        mem_busy = 1'b1; mem_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (ctl !== C_FREEZE) begin fails++; $display("FAIL brwait_freeze_%0d: got %b expected %b", i, ctl, C_FREEZE); end
            tick();
            mem_branch_taken = 1'b0;
        end
        tests++;
        if ({stall_cnt, flush_cnt} !== {4'd3, 4'd0}) begin fails++; $display("FAIL brwait_cnts: got %0d/%0d expected 3/0", stall_cnt, flush_cnt); end
        mem_busy = 1'b0;
        #1;
        tests++;
        if (ctl !== C_FLUSH) begin fails++; $display("FAIL brwait_flush_ctl: got %b expected %b", ctl, C_FLUSH); end
        tick();
        tests++;
        if (flush_cnt !== 4'd1) begin fails++; $display("FAIL brwait_flush_cnt: got %0d expected 1", flush_cnt); end
        tests++;
        if (ctl !== C_NORMAL) begin fails++; $display("FAIL brwait_run_ctl: got %b expected %b", ctl, C_NORMAL); end
        tick();
        tests++;
        if ({stall_cnt, flush_cnt} !== {4'd3, 4'd1}) begin fails++; $display("FAIL brwait_final: got %0d/%0d expected 3/1", stall_cnt, flush_cnt); end

        // WAIT first, then a branch arriving on a later busy cycle.
        do_reset();
        mem_busy = 1'b1;
        tick();
        mem_branch_taken = 1'b1;
        tick();
        mem_branch_taken = 1'b0;
        tick();
        mem_busy = 1'b0;
        #1;
        tests++;
        if (ctl !== C_FLUSH) begin fails++; $display("FAIL wait_late_br_ctl: got %b expected %b", ctl, C_FLUSH); end

        // WAIT releasing straight into a load-use stall.
        do_reset();
        mem_busy = 1'b1;
        tick();
        mem_busy = 1'b0;
        idex_memread = 1'b1; idex_rt = 5'd4; id_rs = 5'd4;
        #1;
        tests++;
        if (ctl !== C_LDUSE) begin fails++; $display("FAIL wait_lduse_ctl: got %b expected %b", ctl, C_LDUSE); end
        tick();
        tests++;
        if (stall_cnt !== 4'd2) begin fails++; $display("FAIL wait_lduse_cnt: got %0d expected 2", stall_cnt); end
    endtask

    task automatic test_forward();
        do_reset();
        exmem_regwrite = 1'b1; memwb_regwrite = 1'b1;
        exmem_rd = 5'd5; memwb_rd = 5'd5; ex_rs = 5'd5; ex_rt = 5'd7;
        #1;
        tests++;
        if ({fwd_a, fwd_b} !== 4'b1000) begin fails++; $display("FAIL fwd_prio: got %b expected 1000", {fwd_a, fwd_b}); end
        exmem_regwrite = 1'b0;
        #1;
        tests++;
        if (fwd_a !== 2'b01) begin fails++; $display("FAIL fwd_wb_a: got %b expected 01", fwd_a); end
        memwb_rd = 5'd7; exmem_regwrite = 1'b1;
        #1;
        tests++;
        if ({fwd_a, fwd_b} !== 4'b1001) begin fails++; $display("FAIL fwd_split: got %b expected 1001", {fwd_a, fwd_b}); end
        memwb_regwrite = 1'b0;
        #1;
        tests++;
        if (fwd_b !== 2'b00) begin fails++; $display("FAIL fwd_b_rf: got %b expected 00", fwd_b); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_busy = 1'b1; mem_branch_taken = 1'b1;
        tick();
        mem_branch_taken = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({stall_cnt, flush_cnt} !== '0) begin fails++; $display("FAIL rstmid_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        tests++;
        if (ctl !== C_RESET) begin fails++; $display("FAIL rstmid_ctl: got %b expected %b", ctl, C_RESET); end
        #1;
        rst = 1'b0; mem_busy = 1'b0;
        #1;
        tests++;
        if (ctl !== C_NORMAL) begin fails++; $display("FAIL rstmid_no_flush: got %b expected %b", ctl, C_NORMAL); end
        tick();
        tests++;
        if (flush_cnt !== 4'd0) begin fails++; $display("FAIL rstmid_flush_cnt: got %0d expected 0", flush_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 18; i++) tick();
        tests++;
        if (stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_stall: got %0d expected 15", stall_cnt); end
        do_reset();
        mem_branch_taken = 1'b1;
        for (int i = 0; i < 18; i++) tick();
        tests++;
        if ({flush_cnt, stall_cnt} !== {4'd15, 4'd0}) begin fails++; $display("FAIL sat_flush: got %0d/%0d expected 15/0", flush_cnt, stall_cnt); end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_zero_guard();
        test_flush();
        test_branch_wait();
        test_forward();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It drives the write/clock enables and bubble/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use stalls, taken-branch flushes (branch resolved in MEM) and data-memory wait states, and produces EX-stage forwarding selects. A small FSM remembers a branch that resolves while memory is busy. Saturating counters expose stall and flush statistics.

## Interface
Parameters:
- CNT_W, 16, width of statistic counters

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  5  source registers of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
- ex_rs, ex_rt  in  5  source registers held in ID/EX
- idex_memread  in  1  ID/EX M-field memread
- idex_rt  in  5  ID/EX rt (load destination)
- exmem_regwrite, exmem_rd  in  1, 5  EX/MEM write-back info (rd already muxed by regdst)
- memwb_regwrite, memwb_rd  in  1, 5  MEM/WB write-back info
- mem_branch_taken  in  1  branch in MEM and ALU zero
- mem_busy  in  1  data memory not ready this cycle
- pc_we  out  1  PC load enable
- ifid_we, ifid_flush  out  1, 1  IF/ID hold / clear to NOP
- idex_ce, idex_bubble  out  1, 1  ID/EX enable / load all-zero ctrl
- exmem_ce, exmem_bubble  out  1, 1  EX/MEM enable / load all-zero ctrl
- fwd_a, fwd_b  out  2  ALU operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- FSM states are RUN, WAIT, WAIT_BR.
- Freeze (mem_busy=1):
  - pc_we, ifid_we, idex_ce and exmem_ce are all 0.
  - No bubble or flush is issued.
  - From RUN: go to WAIT_BR if mem_branch_taken, else WAIT.
  - In WAIT: a mem_branch_taken seen in any busy cycle moves to WAIT_BR.
  - WAIT_BR holds until mem_busy=0.
- Flush (RUN with mem_branch_taken=1, or WAIT_BR with mem_busy=0):
  - ifid_flush, idex_bubble and exmem_bubble are 1.
  - pc_we=1, so the PC takes the branch target.
  - All enables are 1.
  - flush_cnt increments.
  - Next state is RUN.
- Load-use (RUN or WAIT with mem_busy=0, no flush):
  - Condition: idex_memread && idex_rt≠0 && (idex_rt==id_rs || (id_uses_rt && idex_rt==id_rt)).
  - Response: pc_we=0, ifid_we=0, idex_bubble=1, exmem_ce=1.
  - stall_cnt increments.
- Normal: all enables are 1 and all bubble/flush outputs are 0.
- WAIT with mem_busy=0 returns to RUN and applies the load-use or normal rule in that cycle.
- Priority: rst > mem_busy > flush > load-use > normal.
- Forwarding (combinational, independent of FSM):
  - fwd_a=10 if exmem_regwrite && exmem_rd≠0 && exmem_rd==ex_rs.
  - Otherwise fwd_a=01 if memwb_regwrite && memwb_rd≠0 && memwb_rd==ex_rs.
  - Otherwise fwd_a=00.
  - fwd_b uses the same rules with ex_rt.
  - EX/MEM wins over MEM/WB.
- Counters:
  - stall_cnt counts load-use cycles plus freeze cycles.
  - Both counters saturate at all-ones and never wrap.

## Timing
- Control outputs are combinational from state and current inputs, valid before the next rising clk. Zero latency from hazard detection to stall.
- State and counters update on rising clk.
- Reset:
  - rst asserted at any time, including mid-freeze or in WAIT_BR: state goes to RUN and counters to 0 immediately.
  - A captured pending branch is discarded.
  - While rst=1: pc_we=ifid_we=idex_ce=exmem_ce=1, ifid_flush=idex_bubble=exmem_bubble=1, fwd_a=fwd_b=00.
- A load-use stall lasts exactly 1 cycle, because the bubble removes the condition next cycle.
- A flush lasts exactly 1 cycle.
- A branch during freeze is applied in the first cycle with mem_busy=0, not lost and not applied twice.
- Load-use and flush in the same cycle: flush wins and stall_cnt is not incremented.

## Structure
- Package pipe_pkg:
  - FSM state enum {RUN, WAIT, WAIT_BR}.
  - Forward-select constants FWD_RF=00, FWD_MEM=10, FWD_WB=01.
  - CNT_W default.
- Sub-module pipe_fwd_unit: pure combinational forwarding for one operand, instantiated twice (rs, rt).

## Test plan
- Load-use: lw $8 in ID/EX (idex_memread=1, idex_rt=8), id_rs=8 → one cycle of pc_we=0, ifid_we=0, idex_bubble=1, stall_cnt=1. Next cycle, with idex_memread=0, all enables are 1.
- $zero guard: idex_rt=0, id_rs=0, idex_memread=1 → no stall. Forwarding with exmem_rd=0 gives fwd_a=00.
- Branch flush: mem_branch_taken=1 in RUN → ifid_flush=idex_bubble=exmem_bubble=1 and pc_we=1 for 1 cycle, flush_cnt=1.
- Branch during wait: mem_busy=1 for 3 cycles with mem_branch_taken=1 on cycle 1 → 3 freeze cycles (stall_cnt=3), state WAIT_BR, then one flush cycle when mem_busy=0 (flush_cnt=1), then RUN.
- Forward priority: exmem_rd=memwb_rd=ex_rs=5, both regwrite=1 → fwd_a=10. Clearing exmem_regwrite gives fwd_a=01.
- Reset mid-operation: rst pulsed asynchronously while in WAIT_BR → state RUN and counters 0 without a clock edge. After release with mem_busy=0, no flush is issued.
